// File: rtl/mem_pkg.sv
// Shared memory-side types: the buffered store entry and the full-word byte enable.
// Also used by DM and the byte-enable generator.
package mem_pkg;

    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] pc;
    } mem_entry_t;

endpackage

// File: rtl/mem_store_buffer_if.sv
// Pipeline <-> store buffer <-> DM signal bundle.
// The master is the MEM stage; the slave is the store buffer driving the DM port.
interface mem_store_buffer_if;

    logic        IRQ;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wd;
    logic [3:0]  st_be;
    logic [31:0] st_pc;
    logic        st_stall;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic [31:0] dm_a;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic [31:0] dm_pc;
    logic        dm_we;
    logic        dm_re;
    logic        empty;

    modport master (
        output IRQ, st_valid, st_addr, st_wd, st_be, st_pc, ld_valid, ld_addr,
        input  st_stall, ld_stall, dm_a, dm_wd, dm_be, dm_pc, dm_we, dm_re, empty
    );

    modport slave (
        input  IRQ, st_valid, st_addr, st_wd, st_be, st_pc, ld_valid, ld_addr,
        output st_stall, ld_stall, dm_a, dm_wd, dm_be, dm_pc, dm_we, dm_re, empty
    );

endinterface

// File: rtl/sb_fifo.sv
// Circular store FIFO: pointers, occupancy and entry storage.
// Exposes per-entry valid/word-address so the owner can do the load conflict compare.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  mem_entry_t             pushEntry_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output mem_entry_t             head_o,
    output logic [DEPTH-1:0]       entValid_o,
    output logic [DEPTH-1:0][29:0] entWord_o
);

    mem_entry_t       entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        head_d  = pop_i  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push_i ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push_i) begin
                entries_q[tail_q] <= pushEntry_i;
            end
        end
    end

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = entries_q[head_q];

    // A slot is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : gEntry
        logic [PTR_W-1:0] offset;
        assign offset        = PTR_W'(g) - head_q;
        assign entValid_o[g] = ({1'b0, offset} < count_q);
        assign entWord_o[g]  = entries_q[g].addr[31:2];
    end

endmodule

// File: rtl/mem_store_buffer.sv
// Posted-write buffer in front of DM: queues stores, drains them in order when loads
// leave the port free, and stalls loads that hit a word still waiting to be written.
module mem_store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic               clk,
    input logic               reset,
    mem_store_buffer_if.slave bus
);

    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   pushEn;
    logic                   popEn;
    logic                   ldHit;
    logic                   ldConflict;
    mem_entry_t             pushEntry;
    mem_entry_t             headEntry;
    logic [DEPTH-1:0]       entValid;
    logic [DEPTH-1:0][29:0] entWord;

    assign pushEntry    = '{addr: bus.st_addr, wd: bus.st_wd, be: bus.st_be, pc: bus.st_pc};
    assign pushEn       = bus.st_valid && !fifoFull && !reset;
    assign bus.st_stall = bus.st_valid && fifoFull && !reset;
    assign bus.empty    = fifoEmpty || reset;
    assign bus.ld_stall = ldConflict;

    sb_fifo #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (pushEn),
        .pushEntry_i(pushEntry),
        .pop_i      (popEn),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .head_o     (headEntry),
        .entValid_o (entValid),
        .entWord_o  (entWord)
    );

    // Word-granular match against every buffered entry and the store arriving this cycle.
    always_comb begin
        ldHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entValid[i] && (entWord[i] == bus.ld_addr[31:2])) begin
                ldHit = 1'b1;
            end
        end
        if (pushEn && (bus.st_addr[31:2] == bus.ld_addr[31:2])) begin
            ldHit = 1'b1;
        end
        ldConflict = bus.ld_valid && ldHit;
    end

    // Loads own the DM port; the head store drains only when it is idle and no IRQ is taken.
    always_comb begin
        bus.dm_a  = '0;
        bus.dm_wd = '0;
        bus.dm_be = '0;
        bus.dm_pc = '0;
        bus.dm_we = 1'b0;
        bus.dm_re = 1'b0;
        popEn     = 1'b0;
        if (bus.ld_valid && !ldConflict) begin
            bus.dm_a  = bus.ld_addr;
            bus.dm_re = 1'b1;
        end else if (!fifoEmpty && !bus.IRQ && !reset) begin
            bus.dm_a  = headEntry.addr;
            bus.dm_wd = headEntry.wd;
            bus.dm_be = headEntry.be;
            bus.dm_pc = headEntry.pc;
            bus.dm_we = 1'b1;
            bus.dm_re = 1'b1;
            popEn     = 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Scoreboard bench for mem_store_buffer: expected DM writes/reads are queued at stimulus
// time and checked by a monitor that also models DM contents.
module tb_mem_store_buffer;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] pc;
    } expWrite_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] data;
    } expRead_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    expWrite_t   expWrites[$];
    expRead_t    expReads[$];
    expWrite_t   ew;
    expRead_t    er;
    logic [31:0] dmMem [logic [29:0]];
    logic [31:0] mergeWord;

    always #5 clk = ~clk;

    mem_store_buffer_if bus ();

    mem_store_buffer #(
        .DEPTH(4),
        .PTR_W(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] dmRead(input logic [31:0] a);
        if (dmMem.exists(a[31:2])) return dmMem[a[31:2]];
        return 32'h0;
    endfunction

    function automatic void pushWrite(input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] be, input logic [31:0] pc);
        expWrites.push_back('{a, wd, be, pc});
    endfunction

    function automatic void pushRead(input logic [31:0] a, input logic [31:0] data);
        expReads.push_back('{a, data});
    endfunction

    // Monitor and DM model: checks each port use against the queues, then applies writes.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            dmMem.delete();
        end else if (bus.dm_we === 1'b1) begin
            if (expWrites.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedWrite: got write to 0x%08h, want none", bus.dm_a);
            end else begin
                ew = expWrites.pop_front();
                checkOutput("wrAddr", bus.dm_a, ew.a);
                checkOutput("wrData", bus.dm_wd, ew.wd);
                checkOutput("wrBe", {28'h0, bus.dm_be}, {28'h0, ew.be});
                checkOutput("wrPc", bus.dm_pc, ew.pc);
                checkOutput("wrRe", {31'h0, bus.dm_re}, 32'h1);
            end
            mergeWord = dmRead(bus.dm_a);
            for (int b = 0; b < 4; b++) begin
                if (bus.dm_be[b]) mergeWord[8*b +: 8] = bus.dm_wd[8*b +: 8];
            end
            dmMem[bus.dm_a[31:2]] = mergeWord;
        end else if (bus.dm_re === 1'b1) begin
            if (expReads.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedRead: got read of 0x%08h, want none", bus.dm_a);
            end else begin
                er = expReads.pop_front();
                checkOutput("rdAddr", bus.dm_a, er.a);
                checkOutput("rdData", dmRead(bus.dm_a), er.data);
            end
        end
    end

    task automatic applyStimulus(input logic stV, input logic [31:0] stA, input logic [31:0] stWd,
                                 input logic [3:0] stBe, input logic [31:0] stPc,
                                 input logic ldV, input logic [31:0] ldA, input logic irq);
        bus.st_valid = stV;
        bus.st_addr  = stA;
        bus.st_wd    = stWd;
        bus.st_be    = stBe;
        bus.st_pc    = stPc;
        bus.ld_valid = ldV;
        bus.ld_addr  = ldA;
        bus.IRQ      = irq;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll(input string name);
        int n;
        n = 0;
        idle();
        @(negedge clk);
        while (bus.empty !== 1'b1 && n < 20) begin
            nextCycle();
            @(negedge clk);
            n++;
        end
        checkOutput({name, "Drained"}, {31'h0, bus.empty}, 32'h1);
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("rstEmpty", {31'h0, bus.empty}, 32'h1);
        checkOutput("rstStStall", {31'h0, bus.st_stall}, 32'h0);
        checkOutput("rstLdStall", {31'h0, bus.ld_stall}, 32'h0);
        checkOutput("rstWe", {31'h0, bus.dm_we}, 32'h0);
        nextCycle();
        reset = 1'b0;

        // Single store reaches DM the following cycle, buffer empties the cycle after.
        applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, BE_WORD, 32'h400, 1'b0, 32'h0, 1'b0);
        pushWrite(32'h10, 32'hDEAD_BEEF, BE_WORD, 32'h400);
        @(negedge clk);
        checkOutput("t1StStall", {31'h0, bus.st_stall}, 32'h0);
        checkOutput("t1EmptyBefore", {31'h0, bus.empty}, 32'h1);
        checkOutput("t1NoWeYet", {31'h0, bus.dm_we}, 32'h0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("t1We", {31'h0, bus.dm_we}, 32'h1);
        checkOutput("t1NotEmpty", {31'h0, bus.empty}, 32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1EmptyAfter", {31'h0, bus.empty}, 32'h1);
        nextCycle();

        // Held non-matching load blocks draining; fifth store sees a full buffer.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(4*i), 32'h1000 + 32'(i), BE_WORD, 32'h500 + 32'(4*i),
                          1'b1, 32'h100, 1'b0);
            if (i < 4) pushWrite(32'h200 + 32'(4*i), 32'h1000 + 32'(i), BE_WORD, 32'h500 + 32'(4*i));
            pushRead(32'h100, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("t2StStall%0d", i), {31'h0, bus.st_stall}, (i == 4) ? 32'h1 : 32'h0);
            checkOutput($sformatf("t2NoWe%0d", i), {31'h0, bus.dm_we}, 32'h0);
            nextCycle();
        end
        applyStimulus(1'b1, 32'h210, 32'h1004, BE_WORD, 32'h510, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("t2FullStall", {31'h0, bus.st_stall}, 32'h1);
        checkOutput("t2DrainWe", {31'h0, bus.dm_we}, 32'h1);
        nextCycle();
        pushWrite(32'h210, 32'h1004, BE_WORD, 32'h510);
        @(negedge clk);
        checkOutput("t2StallDrop", {31'h0, bus.st_stall}, 32'h0);
        nextCycle();
        drainAll("t2");

        // Partial store followed by a load to the same word stalls until the write lands.
        applyStimulus(1'b1, 32'h20, 32'h0000_00AB, 4'b0001, 32'h600, 1'b0, 32'h0, 1'b0);
        pushWrite(32'h20, 32'h0000_00AB, 4'b0001, 32'h600);
        @(negedge clk);
        checkOutput("t3StStall", {31'h0, bus.st_stall}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h23, 1'b0);
        @(negedge clk);
        checkOutput("t3LdStall", {31'h0, bus.ld_stall}, 32'h1);
        checkOutput("t3DrainWe", {31'h0, bus.dm_we}, 32'h1);
        nextCycle();
        pushRead(32'h23, 32'h0000_00AB);
        @(negedge clk);
        checkOutput("t3LdGo", {31'h0, bus.ld_stall}, 32'h0);
        nextCycle();
        idle();

        // Load matching the store being pushed in the same cycle.
        applyStimulus(1'b1, 32'h40, 32'h4040_4040, BE_WORD, 32'h700, 1'b1, 32'h40, 1'b0);
        pushWrite(32'h40, 32'h4040_4040, BE_WORD, 32'h700);
        @(negedge clk);
        checkOutput("t4LdStall", {31'h0, bus.ld_stall}, 32'h1);
        checkOutput("t4StStall", {31'h0, bus.st_stall}, 32'h0);
        checkOutput("t4NoRe", {31'h0, bus.dm_re}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h40, 1'b0);
        @(negedge clk);
        checkOutput("t4LdStallHeld", {31'h0, bus.ld_stall}, 32'h1);
        checkOutput("t4DrainWe", {31'h0, bus.dm_we}, 32'h1);
        nextCycle();
        pushRead(32'h40, 32'h4040_4040);
        @(negedge clk);
        checkOutput("t4LdGo", {31'h0, bus.ld_stall}, 32'h0);
        nextCycle();
        idle();

        // IRQ holds three buffered stores; matching loads keep stalling; drain resumes on release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h80 + 32'(4*i), 32'hC0DE_0000 + 32'(i), BE_WORD, 32'h800 + 32'(4*i),
                          1'b0, 32'h0, 1'b1);
            pushWrite(32'h80 + 32'(4*i), 32'hC0DE_0000 + 32'(i), BE_WORD, 32'h800 + 32'(4*i));
            @(negedge clk);
            checkOutput($sformatf("t5PushNoWe%0d", i), {31'h0, bus.dm_we}, 32'h0);
            nextCycle();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h80 + 32'(4*i), 1'b1);
            @(negedge clk);
            checkOutput($sformatf("t5IrqNoWe%0d", i), {31'h0, bus.dm_we}, 32'h0);
            checkOutput($sformatf("t5LdStall%0d", i), {31'h0, bus.ld_stall}, 32'h1);
            checkOutput($sformatf("t5NotEmpty%0d", i), {31'h0, bus.empty}, 32'h0);
            nextCycle();
        end
        idle();
        @(negedge clk);
        checkOutput("t5Resume", {31'h0, bus.dm_we}, 32'h1);
        nextCycle();
        drainAll("t5");

        // Reset with buffered stores discards them; their addresses read back as zero.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hC0 + 32'(4*i), 32'h0BAD_0000 + 32'(i), BE_WORD, 32'h900 + 32'(4*i),
                          1'b0, 32'h0, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("t6StStall%0d", i), {31'h0, bus.st_stall}, 32'h0);
            nextCycle();
        end
        reset = 1'b1;
        idle();
        @(negedge clk);
        checkOutput("t6RstWe", {31'h0, bus.dm_we}, 32'h0);
        checkOutput("t6RstEmpty", {31'h0, bus.empty}, 32'h1);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t6EmptyAfter", {31'h0, bus.empty}, 32'h1);
        checkOutput("t6WeAfter", {31'h0, bus.dm_we}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hC0, 1'b0);
        pushRead(32'hC0, 32'h0);
        @(negedge clk);
        checkOutput("t6LdStallA", {31'h0, bus.ld_stall}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hC8, 1'b0);
        pushRead(32'hC8, 32'h0);
        @(negedge clk);
        checkOutput("t6LdStallB", {31'h0, bus.ld_stall}, 32'h0);
        nextCycle();
        idle();

        nextCycle();
        nextCycle();
        checkOutput("writesPending", 32'(expWrites.size()), 32'h0);
        checkOutput("readsPending", 32'(expReads.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
